// File: rtl/axi_spy_drain_arb.sv
// Drains the AR/AW/W/R spy capture FIFOs into one tagged trace stream.
// Round-robin with burst locking; a full FIFO is promoted ahead of the rest.
module axi_spy_drain_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SEQ_WIDTH  = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            spy_empty,
  input  logic [3:0]            spy_full,
  input  logic [ADDR_WIDTH-1:0] ar_spy_data,
  input  logic [ADDR_WIDTH-1:0] aw_spy_data,
  input  logic [DATA_WIDTH-1:0] w_spy_data,
  input  logic [DATA_WIDTH-1:0] r_spy_data,
  output logic [3:0]            spy_rd_en,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic [1:0]            trace_chan,
  output logic [SEQ_WIDTH-1:0]  trace_seq,
  output logic [1:0]            grant_chan,
  output logic                  busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_grant, w_grant_nxt, r_rr_last, w_sel, w_pop_chan;
  logic [BW-1:0]         r_burst, w_burst_nxt;
  logic [3:0]            w_avail, w_urgent, w_cand;
  logic                  w_en, w_load_ok, w_keep, w_pop;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_chan;
  logic [SEQ_WIDTH-1:0]  r_seq;

  // Pops are gated by reset too, so the strobe drops the instant reset asserts.
  assign w_en      = enable & rst_n;
  assign w_avail   = ~spy_empty;
  assign w_urgent  = w_avail & spy_full;
  assign w_cand    = (w_urgent != 4'b0) ? w_urgent : w_avail;
  assign w_load_ok = !r_valid || trace_ready;
  assign w_keep    = w_avail[r_grant] && (r_burst < MAXB) &&
                     ((w_urgent & ~(4'b0001 << r_grant)) == 4'b0);

  // Scan from furthest to nearest so the nearest candidate after rr_last wins.
  always_comb begin
    logic [1:0] idx;
    w_sel = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = r_rr_last + 2'(i);
      if (w_cand[idx]) w_sel = idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_burst_nxt = r_burst;
    w_pop       = 1'b0;
    w_pop_chan  = w_sel;
    if (!w_en) begin
      w_state_nxt = IDLE;
    end else if (w_load_ok) begin
      if (r_state == GRANT && w_keep) begin
        w_pop       = 1'b1;
        w_pop_chan  = r_grant;
        w_burst_nxt = r_burst + BW'(1);
      end else if (w_cand != 4'b0) begin
        w_pop       = 1'b1;
        w_state_nxt = GRANT;
        w_grant_nxt = w_sel;
        w_burst_nxt = BW'(1);
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    case (w_pop_chan)
      2'd0:    w_head = DATA_WIDTH'(ar_spy_data);
      2'd1:    w_head = DATA_WIDTH'(aw_spy_data);
      2'd2:    w_head = w_spy_data;
      default: w_head = r_spy_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= 2'd0;
      r_burst   <= '0;
      r_rr_last <= 2'd3;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_chan    <= 2'd0;
      r_seq     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_burst <= w_burst_nxt;
      if (w_pop) begin
        r_rr_last <= w_pop_chan;
        r_valid   <= 1'b1;
        r_data    <= w_head;
        r_chan    <= w_pop_chan;
        r_seq     <= r_seq + SEQ_WIDTH'(1);
      end else if (trace_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign spy_rd_en   = w_pop ? (4'b0001 << w_pop_chan) : 4'b0000;
  assign trace_valid = r_valid;
  assign trace_data  = r_data;
  assign trace_chan  = r_chan;
  assign trace_seq   = r_seq;
  assign grant_chan  = r_grant;
  assign busy        = (r_state == GRANT) || r_valid;

endmodule

// File: tb/tb_axi_spy_drain_arb.sv
// Bench for axi_spy_drain_arb: FIFO models feed the DUT, a scoreboard holds the
// record each pop must produce and checks it while it sits on the trace port.
module tb_axi_spy_drain_arb;
  localparam int AW = 32, DW = 64, SW = 4, MB = 4;

  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, trace_ready = 1'b0;
  logic [3:0]    spy_empty, spy_full, spy_rd_en;
  logic [AW-1:0] ar_spy_data, aw_spy_data;
  logic [DW-1:0] w_spy_data, r_spy_data, trace_data;
  logic          trace_valid, busy;
  logic [1:0]    trace_chan, grant_chan;
  logic [SW-1:0] trace_seq;

  axi_spy_drain_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEQ_WIDTH(SW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spy_empty(spy_empty), .spy_full(spy_full),
    .ar_spy_data(ar_spy_data), .aw_spy_data(aw_spy_data), .w_spy_data(w_spy_data),
    .r_spy_data(r_spy_data), .spy_rd_en(spy_rd_en), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_chan(trace_chan),
    .trace_seq(trace_seq), .grant_chan(grant_chan), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic [SW-1:0] seq;
  } rec_t;

  rec_t          sb[$];
  rec_t          got[$];
  logic [1:0]    pop_ch[$];
  int            pop_cyc[$];
  logic [DW-1:0] fq [4][$];
  logic [3:0]    full_ovr = 4'b0;
  logic [SW-1:0] exp_seq;
  int            n_chk = 0, n_pass = 0, cyc_n = 0;
  logic [3:0]    s_rd_en;
  logic          s_valid, s_busy;
  logic [1:0]    s_chan;
  logic [SW-1:0] s_seq;

  task automatic refresh();
    for (int c = 0; c < 4; c++) spy_empty[c] = (fq[c].size() == 0);
    ar_spy_data = (fq[0].size() != 0) ? fq[0][0][AW-1:0] : '0;
    aw_spy_data = (fq[1].size() != 0) ? fq[1][0][AW-1:0] : '0;
    w_spy_data  = (fq[2].size() != 0) ? fq[2][0] : '0;
    r_spy_data  = (fq[3].size() != 0) ? fq[3][0] : '0;
    spy_full    = full_ovr;
  endtask

  task automatic fill(input int c, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fq[c].push_back(base + DW'(i));
  endtask

  // One clock: sample at negedge, then apply the FIFO pop just after posedge.
  task automatic cyc();
    int c;
    rec_t e;
    logic [DW-1:0] d;
    c = -1;
    refresh();
    @(negedge clk);
    s_rd_en = spy_rd_en; s_valid = trace_valid; s_busy = busy;
    s_chan = trace_chan; s_seq = trace_seq;
    if (trace_valid || sb.size() != 0) begin
      n_chk++;
      if (sb.size() == 0 || !trace_valid)
        $display("FAIL record_present got valid=%b exp pending=%0d", trace_valid, sb.size());
      else if ({trace_chan, trace_data, trace_seq} !== {sb[0].chan, sb[0].data, sb[0].seq})
        $display("FAIL record got ch=%0d d=%h s=%0d exp ch=%0d d=%h s=%0d", trace_chan,
                 trace_data, trace_seq, sb[0].chan, sb[0].data, sb[0].seq);
      else n_pass++;
      if (trace_valid && trace_ready) begin
        e.chan = trace_chan; e.data = trace_data; e.seq = trace_seq;
        got.push_back(e);
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
    if (spy_rd_en != 4'b0) begin
      n_chk++;
      if (!$onehot(spy_rd_en) || (spy_rd_en & spy_empty) != 4'b0)
        $display("FAIL rd_en_legal got %b exp one-hot non-empty (empty=%b)", spy_rd_en, spy_empty);
      else n_pass++;
      for (int i = 0; i < 4; i++) if (spy_rd_en[i]) c = i;
      if (fq[c].size() != 0) begin
        d = fq[c][0];
        e.chan = 2'(c);
        e.data = (c < 2) ? {{(DW-AW){1'b0}}, d[AW-1:0]} : d;
        exp_seq = exp_seq + SW'(1);
        e.seq = exp_seq;
        sb.push_back(e);
        pop_ch.push_back(2'(c));
        pop_cyc.push_back(cyc_n);
      end
    end
    @(posedge clk); #1;
    if (c >= 0 && fq[c].size() != 0) void'(fq[c].pop_front());
    cyc_n++;
    refresh();
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin cyc(); k++; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; trace_ready = 1'b0; full_ovr = 4'b0;
    for (int c = 0; c < 4; c++) fq[c].delete();
    sb.delete(); got.delete(); pop_ch.delete(); pop_cyc.delete();
    exp_seq = '0;
    refresh();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    enable = 1'b1;
    fill(0, 1, 64'hFFFF_0000_8000_0011);
    fill(1, 1, 64'h0000_0000_8000_0022);
    rst_n = 1'b0;
    refresh();
    #1;
    n_chk++; if (spy_rd_en !== 4'b0) $display("FAIL rst_rd_en got %b exp 0000", spy_rd_en); else n_pass++;
    n_chk++; if (trace_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", trace_valid); else n_pass++;
    n_chk++; if (trace_data !== '0) $display("FAIL rst_data got %h exp 0", trace_data); else n_pass++;
    n_chk++; if (trace_chan !== 2'd0) $display("FAIL rst_chan got %0d exp 0", trace_chan); else n_pass++;
    n_chk++; if (trace_seq !== '0) $display("FAIL rst_seq got %0d exp 0", trace_seq); else n_pass++;
    n_chk++; if (grant_chan !== 2'd0) $display("FAIL rst_grant got %0d exp 0", grant_chan); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    trace_ready = 1'b1;
    cyc();
    n_chk++; if (s_rd_en !== 4'b0001) $display("FAIL first_pick got %b exp 0001", s_rd_en); else n_pass++;
    cyc();
    n_chk++; if (s_valid !== 1'b1 || s_seq !== SW'(1) || s_chan !== 2'd0)
      $display("FAIL first_record got v=%b s=%0d ch=%0d exp v=1 s=1 ch=0", s_valid, s_seq, s_chan);
    else n_pass++;
    repeat (3) cyc();
  endtask

  task automatic test_single_w();
    do_reset();
    fq[2].push_back(64'hA1); fq[2].push_back(64'hA2); fq[2].push_back(64'hA3);
    enable = 1'b1; trace_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++; if (s_rd_en !== 4'b0100) $display("FAIL single_rd_en[%0d] got %b exp 0100", k, s_rd_en); else n_pass++;
    end
    cyc();
    n_chk++; if (s_rd_en !== 4'b0000) $display("FAIL single_stop got %b exp 0000", s_rd_en); else n_pass++;
    cyc();
    n_chk++; if (s_busy !== 1'b0 || s_valid !== 1'b0)
      $display("FAIL single_idle got busy=%b valid=%b exp 0 0", s_busy, s_valid);
    else n_pass++;
    n_chk++; if (got.size() != 3) $display("FAIL single_count got %0d exp 3", got.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_chk++;
      if (got[i].chan !== 2'd2 || got[i].seq !== SW'(i + 1) || got[i].data !== DW'(64'hA1 + i))
        $display("FAIL single_rec[%0d] got ch=%0d s=%0d d=%h exp ch=2 s=%0d d=%h", i, got[i].chan,
                 got[i].seq, got[i].data, i + 1, 64'hA1 + i);
      else n_pass++;
    end
  endtask

  task automatic test_rr_burst();
    logic [1:0] exp_ch[$];
    int rem[4];
    do_reset();
    for (int c = 0; c < 4; c++) begin
      fill(c, 10, 64'hDEAD_0000_8000_0000 | DW'(c << 8));
      rem[c] = 10;
    end
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < MB && rem[c] > 0; k++) begin exp_ch.push_back(2'(c)); rem[c]--; end
    enable = 1'b1; trace_ready = 1'b1;
    run_until(40, 120);
    n_chk++; if (got.size() != 40) $display("FAIL rr_count got %0d exp 40", got.size()); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      n_chk++;
      if (i >= pop_ch.size() || pop_ch[i] !== exp_ch[i])
        $display("FAIL rr_order[%0d] got %0d exp %0d", i, (i < pop_ch.size()) ? pop_ch[i] : 2'd0, exp_ch[i]);
      else n_pass++;
    end
    n_chk++;
    if (pop_cyc.size() != 40 || pop_cyc[39] - pop_cyc[0] != 39)
      $display("FAIL rr_no_gap got span=%0d exp 39", (pop_cyc.size() == 40) ? pop_cyc[39] - pop_cyc[0] : -1);
    else n_pass++;
  endtask

  task automatic test_urgent();
    logic [1:0] exp_ch[$] = '{0, 0, 3, 3, 3, 3, 0, 0, 0, 0, 3, 3, 3, 3, 0, 0};
    do_reset();
    fill(0, 8, 64'h0000_0001_8000_0100);
    fill(3, 8, 64'h3333_0000_0000_0300);
    enable = 1'b1; trace_ready = 1'b1;
    cyc(); cyc();
    full_ovr[3] = 1'b1;
    cyc();
    n_chk++; if (s_rd_en !== 4'b1000) $display("FAIL urgent_preempt got %b exp 1000", s_rd_en); else n_pass++;
    cyc(); cyc();
    full_ovr[3] = 1'b0;
    run_until(16, 40);
    n_chk++; if (pop_ch.size() != 16) $display("FAIL urgent_count got %0d exp 16", pop_ch.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (i >= pop_ch.size() || pop_ch[i] !== exp_ch[i])
        $display("FAIL urgent_order[%0d] got %0d exp %0d", i, (i < pop_ch.size()) ? pop_ch[i] : 2'd0, exp_ch[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(0, 6, 64'h0000_0000_8000_0500);
    enable = 1'b1; trace_ready = 1'b1;
    cyc();
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_chk++;
      if (s_rd_en !== 4'b0 || s_valid !== 1'b1 || s_seq !== SW'(1) || s_chan !== 2'd0)
        $display("FAIL bp_hold[%0d] got rd=%b v=%b s=%0d ch=%0d exp rd=0000 v=1 s=1 ch=0", k,
                 s_rd_en, s_valid, s_seq, s_chan);
      else n_pass++;
    end
    trace_ready = 1'b1;
    cyc();
    n_chk++; if (s_rd_en !== 4'b0001) $display("FAIL bp_resume got %b exp 0001", s_rd_en); else n_pass++;
    cyc();
    n_chk++; if (s_valid !== 1'b1 || s_seq !== SW'(2))
      $display("FAIL bp_next got v=%b s=%0d exp v=1 s=2", s_valid, s_seq);
    else n_pass++;
    run_until(6, 30);
    n_chk++; if (got.size() != 6) $display("FAIL bp_count got %0d exp 6", got.size()); else n_pass++;
  endtask

  task automatic test_seq_wrap();
    do_reset();
    fill(2, 17, 64'h5555_0000_0000_0000);
    enable = 1'b1; trace_ready = 1'b1;
    run_until(17, 60);
    n_chk++; if (got.size() != 17) $display("FAIL wrap_count got %0d exp 17", got.size()); else n_pass++;
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      n_chk++;
      if (got[i].seq !== SW'((i + 1) % 16))
        $display("FAIL wrap_seq[%0d] got %0d exp %0d", i, got[i].seq, (i + 1) % 16);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    fill(0, 8, 64'h0000_0000_8000_0700);
    enable = 1'b1; trace_ready = 1'b1;
    cyc(); cyc();
    enable = 1'b0; trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++;
      if (s_rd_en !== 4'b0 || s_valid !== 1'b1 || s_seq !== SW'(2))
        $display("FAIL en_hold[%0d] got rd=%b v=%b s=%0d exp rd=0000 v=1 s=2", k, s_rd_en, s_valid, s_seq);
      else n_pass++;
    end
    trace_ready = 1'b1;
    cyc(); cyc();
    n_chk++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_rd_en !== 4'b0)
      $display("FAIL en_idle got v=%b busy=%b rd=%b exp 0 0 0000", s_valid, s_busy, s_rd_en);
    else n_pass++;
    enable = 1'b1;
    cyc();
    n_chk++; if (s_rd_en !== 4'b0001) $display("FAIL en_resume got %b exp 0001", s_rd_en); else n_pass++;
    cyc();
    n_chk++; if (spy_rd_en !== 4'b0001 || trace_valid !== 1'b1)
      $display("FAIL mid_burst got rd=%b v=%b exp 0001 1", spy_rd_en, trace_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (trace_valid !== 1'b0 || spy_rd_en !== 4'b0)
      $display("FAIL async_rst got v=%b rd=%b exp 0 0000", trace_valid, spy_rd_en);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    refresh();
    test_reset();
    test_single_w();
    test_rr_burst();
    test_urgent();
    test_backpressure();
    test_seq_wrap();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
